// File: rtl/serial_unrotator_pkg.sv
// Shared types and constants for the serial unrotator: FSM encoding, direction codes, default sizes.
package serial_unrotator_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_SC_W  = 3;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_unrotator_rot1.sv
// Combinational single-position rotate; dir_i selects left (DIR_LEFT) or right (DIR_RIGHT).
module rot1_step
    import serial_unrotator_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] d_i,
    input  logic             dir_i,
    output logic [WIDTH-1:0] q_o
);

    always_comb begin
        if (dir_i == DIR_LEFT) begin
            q_o = {d_i[WIDTH-2:0], d_i[WIDTH-1]};
        end else begin
            q_o = {d_i[0], d_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/serial_unrotator.sv
// Recovers A from B = rot(A, SC, dir) by rotating one bit per clock the opposite way.
// Optional UNROT_STATS_EN adds a 16-bit count of completed output handshakes (op_count).
//
// state | meaning
// IDLE  | in_ready high, waiting for a request
// SHIFT | undoing the rotation, cnt counts remaining steps down to 1
// DONE  | out_valid high, holding the result until out_ready
module serial_unrotator
    import serial_unrotator_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SC_W  = DEF_SC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] B_in,
    input  logic [SC_W-1:0]  SC_in,
    input  logic             dir_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] A_out,
    output logic             busy
`ifdef UNROT_STATS_EN
    ,
    output logic [15:0]      op_count
`endif
);

    state_t           state_q, state_d;
    logic [SC_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] sreg_step;
    logic             step_dir;

    // Undo runs against the direction that produced B.
    assign step_dir = (dir_q == DIR_LEFT) ? DIR_RIGHT : DIR_LEFT;

    rot1_step #(.WIDTH(WIDTH)) u_rot1 (
        .d_i   (sreg_q),
        .dir_i (step_dir),
        .q_o   (sreg_step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sreg_q  <= '0;
            dir_q   <= DIR_LEFT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        dir_d   = dir_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sreg_d  = B_in;
                    cnt_d   = SC_in;
                    dir_d   = dir_in;
                    state_d = (SC_in != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                sreg_d = sreg_step;
                cnt_d  = cnt_q - SC_W'(1);
                if (cnt_q == SC_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign A_out     = sreg_q;

`ifdef UNROT_STATS_EN
    logic [15:0] op_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            op_count_q <= '0;
        end else if (out_valid && out_ready) begin
            op_count_q <= op_count_q + 16'd1;
        end
    end

    assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_serial_unrotator.sv
// Self-checking bench for serial_unrotator: directed cases, reset abort, full sweep, back-to-back.
module tb_serial_unrotator;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] B_in;
    logic [2:0] SC_in;
    logic       dir_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] A_out;
    logic       busy;
`ifdef UNROT_STATS_EN
    logic [15:0] op_count;
    logic [15:0] oc_mark;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];

    serial_unrotator #(.WIDTH(8), .SC_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .B_in      (B_in),
        .SC_in     (SC_in),
        .dir_in    (dir_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .A_out     (A_out),
        .busy      (busy)
`ifdef UNROT_STATS_EN
        ,
        .op_count  (op_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Independent reference: dir 0 -> rotl(a,sc), dir 1 -> rotr(a,sc)
    function automatic logic [7:0] rot_ref(input logic [7:0] a, input int sc, input logic dir);
        logic [15:0] t;
        t = {a, a};
        if (dir == 1'b0) begin
            t = t << sc;
            return t[15:8];
        end
        t = t >> sc;
        return t[7:0];
    endfunction

    task automatic pop_check(input string tag);
        check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) check(tag, 32'(A_out), 32'(sb.pop_front()));
    endtask

    // Entered and left on a falling edge with the unit idle.
    task automatic op(input logic [7:0] a, input int sc, input logic dir, input int hold, input logic pulse);
        logic [7:0] held;
        int n;
        check("idle_in_ready", 32'(in_ready), 32'd1);
        B_in      = rot_ref(a, sc, dir);
        SC_in     = 3'(sc);
        dir_in    = dir;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        sb.push_back(a);
        @(negedge clk);
        in_valid = 1'b0;
        B_in     = 8'($urandom);
        n = 1;
        while (!out_valid && n < 40) begin
            check("shift_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(sc + 1));
        held = A_out;
        for (int k = 0; k < hold; k++) begin
            if (pulse) begin
                in_valid = 1'b1;
                B_in     = 8'($urandom);
                SC_in    = 3'($urandom);
            end
            @(negedge clk);
            in_valid = 1'b0;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_A_out", 32'(A_out), 32'(held));
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        check("out_valid", 32'(out_valid), 32'd1);
        pop_check("A_out");
        @(negedge clk);
        check("post_in_ready", 32'(in_ready), 32'd1);
        check("post_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int scs[4];
        logic [7:0] as[4];
        int idx, done_cnt, cyc, last_acc;
        logic seen;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        B_in = '0; SC_in = '0; dir_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_A_out", 32'(A_out), 32'd0);
`ifdef UNROT_STATS_EN
        check("rst_op_count", 32'(op_count), 32'd0);
`endif

        // Directed cases
        op(8'b1100_0000, 2, 1'b0, 0, 1'b0);
        check("t1_A_out", 32'(A_out), 32'hC0);
        op(8'h03, 1, 1'b1, 0, 1'b0);
        op(8'hA5, 0, 1'b0, 0, 1'b0);
        op(8'hB4, 7, 1'b0, 4, 1'b1);
        check("t3_sb_empty", 32'(sb.size()), 32'd0);

        // Reset aborts an operation mid-shift
`ifdef UNROT_STATS_EN
        oc_mark = op_count;
`endif
        B_in = rot_ref(8'h3C, 7, 1'b1); SC_in = 3'd7; dir_in = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_A_out", 32'(A_out), 32'd0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_spurious", 32'(seen), 32'd0);
`ifdef UNROT_STATS_EN
        check("abort_op_count", 32'(op_count), 32'(oc_mark));
        oc_mark = op_count;
`endif

        // Exhaustive sweep
        for (int a = 0; a < 256; a++)
            for (int sc = 0; sc < 8; sc++)
                for (int d = 0; d < 2; d++)
                    op(8'(a), sc, 1'(d), 0, 1'b0);
`ifdef UNROT_STATS_EN
        check("sweep_op_count", 32'(16'(op_count - oc_mark)), 32'd4096);
`endif

        // Back-to-back requests with in_valid held high
        scs[0] = 3; scs[1] = 0; scs[2] = 7; scs[3] = 1;
        as[0] = 8'h1E; as[1] = 8'h77; as[2] = 8'h80; as[3] = 8'h6D;
        idx = 0; done_cnt = 0; cyc = 0; last_acc = 0;
        out_ready = 1'b1;
        B_in = rot_ref(as[0], scs[0], 1'b1); SC_in = 3'(scs[0]); dir_in = 1'b1;
        in_valid = 1'b1;
        while (done_cnt < 4 && cyc < 200) begin
            if (out_valid) begin
                pop_check("b2b_A_out");
                done_cnt++;
            end
            if (in_ready && idx < 4) begin
                sb.push_back(as[idx]);
                if (idx > 0) check("b2b_spacing", 32'(cyc - last_acc), 32'(scs[idx-1] + 2));
                last_acc = cyc;
                idx++;
                @(negedge clk);
                cyc++;
                if (idx < 4) begin
                    B_in = rot_ref(as[idx], scs[idx], 1'b1);
                    SC_in = 3'(scs[idx]);
                end else begin
                    in_valid = 1'b0;
                end
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        check("b2b_all_done", 32'(done_cnt), 32'd4);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
